// File: rtl/flash_bridge.sv
// flash_bridge: HPS-to-fabric bridge for schedule, change-queue and tick handshakes
module flash_bridge #(
    parameter int PID_W    = 16,
    parameter int PRI_W    = 8,
    parameter int TYPE_W   = 8,
    parameter int STATE_W  = 16,
    parameter int CQ_DEPTH = 4,
    localparam int CD_W    = TYPE_W + PID_W + PRI_W + STATE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hps_req,
    input  logic               hps_address,
    input  logic [CD_W-1:0]    hps_change_data,
    input  logic               hps_read,
    output logic [PID_W:0]     hps_next_process,
    output logic               hps_tick_irq,
    output logic               hps_cq_full,
    output logic [7:0]         hps_drop_cnt,
    output logic               f_sched_req,
    input  logic               f_sched_grant,
    input  logic [PID_W-1:0]   f_next_process,
    input  logic               f_tick_req,
    output logic               f_tick_grant,
    output logic               f_change_req,
    input  logic               f_change_grant,
    output logic [TYPE_W-1:0] f_change_type,
    output logic [PID_W-1:0]   f_change_pid,
    output logic [PRI_W-1:0]   f_change_pri,
    output logic [STATE_W-1:0] f_change_state
);
    localparam int AW = $clog2(CQ_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} sched_e;
    typedef enum logic [1:0] {C_IDLE, C_REQ, C_WAIT} change_e;

    sched_e            s_q, s_d;
    change_e           c_q, c_d;
    logic              sreq_q, sreq_d;
    logic              nv_q, nv_d;
    logic [PID_W-1:0]  npid_q, npid_d;
    logic              creq_q, creq_d;
    logic [CD_W-1:0]   cword_q, cword_d;
    logic              tg_q, tg_d;
    logic              irq_q, irq_d;
    logic [7:0]        drop_q, drop_d;
    logic [AW-1:0]     wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              full_q, full_d;
    logic [CD_W-1:0]   mem_q [CQ_DEPTH];
    logic [CD_W-1:0]   mem_d [CQ_DEPTH];
    logic              sched_in, chg_in, push, pop, capture, drop;

    // next-state logic for the schedule, change-queue and tick paths
    always_comb begin
        sched_in = hps_req && !hps_address;
        chg_in   = hps_req && hps_address;
        push     = chg_in && !full_q;
        pop      = (c_q == C_REQ) && f_change_grant;
        capture  = (s_q == S_REQ) && f_sched_grant;
        drop     = (sched_in && s_q != S_IDLE) || (chg_in && full_q);
        s_d      = s_q;
        sreq_d   = sreq_q;
        case (s_q)
            S_IDLE:  if (sched_in) begin s_d = S_REQ; sreq_d = 1'b1; end
            S_REQ:   if (f_sched_grant) begin s_d = S_WAIT; sreq_d = 1'b0; end
            S_WAIT:  if (!f_sched_grant) s_d = S_IDLE;
            default: begin s_d = S_IDLE; sreq_d = 1'b0; end
        endcase
        nv_d    = capture || (nv_q && !hps_read);
        npid_d  = capture ? f_next_process : npid_q;
        c_d     = c_q;
        creq_d  = creq_q;
        cword_d = cword_q;
        case (c_q)
            C_IDLE:  if (cnt_q != '0) begin c_d = C_REQ; creq_d = 1'b1; cword_d = mem_q[rp_q]; end
            C_REQ:   if (f_change_grant) begin c_d = C_WAIT; creq_d = 1'b0; end
            C_WAIT:  if (!f_change_grant) c_d = C_IDLE;
            default: begin c_d = C_IDLE; creq_d = 1'b0; end
        endcase
        mem_d = mem_q;
        if (push) mem_d[wp_q] = hps_change_data;
        wp_d   = wp_q + AW'(push);
        rp_d   = rp_q + AW'(pop);
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        full_d = cnt_d == CW'(CQ_DEPTH);
        // the four-phase tick grant simply echoes the request one cycle later
        tg_d   = f_tick_req;
        irq_d  = (f_tick_req && !tg_q) ? 1'b1 : (hps_read && !f_tick_req && !tg_q) ? 1'b0 : irq_q;
        drop_d = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end

    // state registers; reset abandons any handshake and empties the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= S_IDLE;
            c_q     <= C_IDLE;
            sreq_q  <= 1'b0;
            nv_q    <= 1'b0;
            npid_q  <= '0;
            creq_q  <= 1'b0;
            cword_q <= '0;
            tg_q    <= 1'b0;
            irq_q   <= 1'b0;
            drop_q  <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            for (int i = 0; i < CQ_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            s_q     <= s_d;
            c_q     <= c_d;
            sreq_q  <= sreq_d;
            nv_q    <= nv_d;
            npid_q  <= npid_d;
            creq_q  <= creq_d;
            cword_q <= cword_d;
            tg_q    <= tg_d;
            irq_q   <= irq_d;
            drop_q  <= drop_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            mem_q   <= mem_d;
        end
    end

    assign hps_next_process = {nv_q, npid_q};
    assign hps_tick_irq     = irq_q;
    assign hps_cq_full      = full_q;
    assign hps_drop_cnt     = drop_q;
    assign f_sched_req      = sreq_q;
    assign f_tick_grant     = tg_q;
    assign f_change_req     = creq_q;
    assign f_change_type    = cword_q[TYPE_W-1:0];
    assign f_change_pid     = cword_q[TYPE_W +: PID_W];
    assign f_change_pri     = cword_q[TYPE_W+PID_W +: PRI_W];
    assign f_change_state   = cword_q[TYPE_W+PID_W+PRI_W +: STATE_W];
endmodule
